// File: rtl/arithmetic_block_1bit.sv
`default_nettype none
// ============================================================================
// Module   : arithmetic_block_1bit
// Brief    : One-bit registered arithmetic slice (8 ops on A, B, Cin) for the
//            ripple-carry datapath; optional registered P/G via ARITH_BLOCK_PG_EN.
// Revision : 1.0  initial release
// ============================================================================
module arithmetic_block_1bit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    input  logic [2:0] opsel,
    output logic       Result,
    output logic       Cout,
    output logic       Ovf
`ifdef ARITH_BLOCK_PG_EN
    ,
    output logic       P,
    output logic       G
`endif
);

    localparam logic [2:0] c_OP_ADD   = 3'b000;
    localparam logic [2:0] c_OP_SUB   = 3'b001;
    localparam logic [2:0] c_OP_INC   = 3'b010;
    localparam logic [2:0] c_OP_DEC   = 3'b011;
    localparam logic [2:0] c_OP_PASSA = 3'b100;
    localparam logic [2:0] c_OP_NEG   = 3'b101;
    localparam logic [2:0] c_OP_RSUB  = 3'b110;
    localparam logic [2:0] c_OP_PASSB = 3'b111;

    logic w_x;
    logic w_y;
    logic w_pass;
    logic w_pass_val;
    logic w_sum;
    logic w_carry;
    logic w_result;
    logic w_cout;
    logic w_ovf;

    logic r_result;
    logic r_cout;
    logic r_ovf;

    // Operand steering: pass ops bypass the adder and force carry to zero.
    always_comb begin
        w_x        = 1'b0;
        w_y        = 1'b0;
        w_pass     = 1'b0;
        w_pass_val = 1'b0;
        case (opsel)
            c_OP_ADD:   begin w_x = A;  w_y = B;    end
            c_OP_SUB:   begin w_x = A;  w_y = ~B;   end
            c_OP_INC:   begin w_x = A;  w_y = 1'b0; end
            c_OP_DEC:   begin w_x = A;  w_y = 1'b1; end
            c_OP_PASSA: begin w_pass = 1'b1; w_pass_val = A; end
            c_OP_NEG:   begin w_x = ~A; w_y = 1'b0; end
            c_OP_RSUB:  begin w_x = B;  w_y = ~A;   end
            c_OP_PASSB: begin w_pass = 1'b1; w_pass_val = B; end
            default:    begin w_x = 1'b0; w_y = 1'b0; end
        endcase
    end

    assign w_sum    = w_x ^ w_y ^ Cin;
    assign w_carry  = (w_x & w_y) | (Cin & (w_x ^ w_y));
    assign w_result = w_pass ? w_pass_val : w_sum;
    assign w_cout   = w_pass ? 1'b0 : w_carry;
    assign w_ovf    = w_pass ? 1'b0 : (Cin ^ w_carry);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_result <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_result;
            r_cout   <= w_cout;
            r_ovf    <= w_ovf;
        end
    end

    assign Result = r_result;
    assign Cout   = r_cout;
    assign Ovf    = r_ovf;

`ifdef ARITH_BLOCK_PG_EN
    logic w_p;
    logic w_g;
    logic r_p;
    logic r_g;

    assign w_p = w_pass ? 1'b0 : (w_x ^ w_y);
    assign w_g = w_pass ? 1'b0 : (w_x & w_y);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_p <= 1'b0;
            r_g <= 1'b0;
        end else begin
            r_p <= w_p;
            r_g <= w_g;
        end
    end

    assign P = r_p;
    assign G = r_g;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arithmetic_block_1bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_arithmetic_block_1bit
// Brief    : Self-checking bench: directed cases, exhaustive sweep with a
//            mid-stream reset, and random traffic against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_arithmetic_block_1bit;

    logic       Clk;
    logic       Reset;
    logic       A;
    logic       B;
    logic       Cin;
    logic [2:0] opsel;
    logic       Result;
    logic       Cout;
    logic       Ovf;
`ifdef ARITH_BLOCK_PG_EN
    logic       P;
    logic       G;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    arithmetic_block_1bit u_dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .opsel  (opsel),
        .Result (Result),
        .Cout   (Cout),
        .Ovf    (Ovf)
`ifdef ARITH_BLOCK_PG_EN
        ,
        .P      (P),
        .G      (G)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Returns {result, cout, ovf, p, g} using integer arithmetic on the operands.
    function automatic logic [4:0] model(input int a, input int b, input int cin, input int op);
        int x;
        int y;
        int t;
        int c;
        x = 0;
        y = 0;
        case (op)
            0: begin x = a;     y = b;     end
            1: begin x = a;     y = 1 - b; end
            2: begin x = a;     y = 0;     end
            3: begin x = a;     y = 1;     end
            4: return {a[0], 4'b0000};
            5: begin x = 1 - a; y = 0;     end
            6: begin x = b;     y = 1 - a; end
            default: return {b[0], 4'b0000};
        endcase
        t = x + y + cin;
        c = t / 2;
        return {1'(t % 2), 1'(c), 1'(cin != c), 1'((x + y) == 1), 1'((x + y) == 2)};
    endfunction

    task automatic step(input string tag, input logic a, input logic b, input logic cin,
                        input logic [2:0] op, input logic rst);
        logic [4:0] exp;
        A     = a;
        B     = b;
        Cin   = cin;
        opsel = op;
        Reset = rst;
        exp   = rst ? 5'b0 : model(int'(a), int'(b), int'(cin), int'(op));
        @(posedge Clk);
        #1;
        chk({tag, ".result"}, Result, exp[4]);
        chk({tag, ".cout"},   Cout,   exp[3]);
        chk({tag, ".ovf"},    Ovf,    exp[2]);
`ifdef ARITH_BLOCK_PG_EN
        chk({tag, ".p"},      P,      exp[1]);
        chk({tag, ".g"},      G,      exp[0]);
`endif
    endtask

    initial begin
        Reset = 1'b1;
        A = 1'b1; B = 1'b1; Cin = 1'b1; opsel = 3'b000;

        // Reset held for two edges with live inputs, then release.
        step("rst0", 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);
        step("rst1", 1'b1, 1'b1, 1'b1, 3'b000, 1'b1);
        step("add111", 1'b1, 1'b1, 1'b1, 3'b000, 1'b0);

        step("sub011", 1'b0, 1'b1, 1'b1, 3'b001, 1'b0);
        step("sub101", 1'b1, 1'b0, 1'b1, 3'b001, 1'b0);
        step("dec", 1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
        step("neg", 1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
        step("passa", 1'b1, 1'b0, 1'b1, 3'b100, 1'b0);
        step("passb", 1'b1, 1'b0, 1'b1, 3'b111, 1'b0);

        // Exhaustive back-to-back sweep; one reset edge injected mid-stream.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            step($sformatf("sweep%0d", i), v[0], v[1], v[2], v[5:3], 1'b0);
            if (i == 37)
                step("midrst", v[0], v[1], v[2], v[5:3], 1'b1);
        end

        // Random traffic with occasional reset edges.
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
